// File: rtl/bcd_serial_addsub.sv
// Digit-serial sign-magnitude BCD adder/subtractor: one digit per clock, LSB first.
// Latency: 1 (invalid), DIGITS+1, or 2*DIGITS+1 (ten's complement pass); start is ignored while busy.
module bcd_serial_addsub #(
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  sub,
    input  logic                  a_sign,
    input  logic [4*DIGITS-1:0]   a_mag,
    input  logic                  b_sign,
    input  logic [4*DIGITS-1:0]   b_mag,
    output logic                  busy,
    output logic                  done,
    output logic                  r_sign,
    output logic [4*DIGITS-1:0]   r_mag,
    output logic                  overflow,
    output logic                  invalid
);

    localparam int W  = 4 * DIGITS;
    localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_ADD,
        S_CMPL,
        S_DONE
    } state_t;

    state_t          r_state;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic [W-1:0]    r_acc;
    logic            r_asign;
    logic            r_eff_sub;
    logic            r_carry;
    logic [CW-1:0]   r_cnt;

    logic            w_bad;
    logic [3:0]      w_x;
    logic [3:0]      w_y;
    logic [4:0]      w_sum;
    logic            w_gt9;
    logic [3:0]      w_digit;
    logic [W+3:0]    w_shift;
    logic [W-1:0]    w_next_acc;
    logic            w_last;
    logic            w_to_cmpl;
    logic            w_fin_sign;
    logic            w_fin_ov;

    always_comb begin
        w_bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_a[4*i +: 4] > 4'd9 || r_b[4*i +: 4] > 4'd9) begin
                w_bad = 1'b1;
            end
        end
    end

    // The same digit adder serves both passes: CMPL feeds (9-digit)+carry with a zero addend.
    always_comb begin
        w_x = r_a[3:0];
        w_y = r_eff_sub ? (4'd9 - r_b[3:0]) : r_b[3:0];
        if (r_state == S_CMPL) begin
            w_x = 4'd9 - r_acc[3:0];
            w_y = 4'd0;
        end
    end

    assign w_sum      = {1'b0, w_x} + {1'b0, w_y} + {4'b0000, r_carry};
    assign w_gt9      = (w_sum > 5'd9);
    assign w_digit    = w_gt9 ? (w_sum[3:0] + 4'd6) : w_sum[3:0];
    assign w_shift    = {w_digit, r_acc};
    assign w_next_acc = w_shift[W+3:4];
    assign w_last     = (r_cnt == CW'(DIGITS - 1));
    assign w_to_cmpl  = (r_state == S_ADD) && r_eff_sub && !w_gt9;
    assign w_fin_sign = (r_state == S_CMPL) ? ~r_asign : r_asign;
    assign w_fin_ov   = (r_state == S_ADD) && !r_eff_sub && w_gt9;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_a       <= '0;
            r_b       <= '0;
            r_acc     <= '0;
            r_asign   <= 1'b0;
            r_eff_sub <= 1'b0;
            r_carry   <= 1'b0;
            r_cnt     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            r_sign    <= 1'b0;
            r_mag     <= '0;
            overflow  <= 1'b0;
            invalid   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a       <= a_mag;
                        r_b       <= b_mag;
                        r_asign   <= a_sign;
                        r_eff_sub <= a_sign ^ b_sign ^ sub;
                        r_carry   <= a_sign ^ b_sign ^ sub;
                        r_cnt     <= '0;
                        busy      <= 1'b1;
                        r_state   <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (w_bad) begin
                        r_state  <= S_DONE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        invalid  <= 1'b1;
                        r_sign   <= 1'b0;
                        r_mag    <= '0;
                        overflow <= 1'b0;
                    end else begin
                        r_state <= S_ADD;
                    end
                end
                S_ADD, S_CMPL: begin
                    r_a     <= r_a >> 4;
                    r_b     <= r_b >> 4;
                    r_acc   <= w_next_acc;
                    r_carry <= w_gt9;
                    r_cnt   <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_cnt <= '0;
                        if (w_to_cmpl) begin
                            r_state <= S_CMPL;
                            r_carry <= 1'b1;
                        end else begin
                            r_state  <= S_DONE;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            invalid  <= 1'b0;
                            r_mag    <= w_next_acc;
                            overflow <= w_fin_ov;
                            r_sign   <= (w_next_acc == '0) ? 1'b0 : w_fin_sign;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_serial_addsub.sv
// Scoreboarded bench for bcd_serial_addsub (DIGITS=3): directed corner cases, then random operations.
module tb_bcd_serial_addsub;

    localparam int D = 3;
    localparam int W = 4 * D;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         sub = 1'b0;
    logic         a_sign = 1'b0;
    logic         b_sign = 1'b0;
    logic [W-1:0] a_mag = '0;
    logic [W-1:0] b_mag = '0;
    logic         busy;
    logic         done;
    logic         r_sign;
    logic [W-1:0] r_mag;
    logic         overflow;
    logic         invalid;

    bcd_serial_addsub #(.DIGITS(D)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub),
        .a_sign(a_sign), .a_mag(a_mag), .b_sign(b_sign), .b_mag(b_mag),
        .busy(busy), .done(done), .r_sign(r_sign), .r_mag(r_mag),
        .overflow(overflow), .invalid(invalid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         s;
        logic [W-1:0] m;
        logic         ov;
        logic         inv;
        int           lat;
        int           acc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   ndone = 0;

    logic         h_s = 1'b0;
    logic [W-1:0] h_m = '0;
    logic         h_ov = 1'b0;
    logic         h_inv = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic int bcd2int(input logic [W-1:0] m);
        int v = 0;
        for (int i = D - 1; i >= 0; i--) v = v * 10 + int'(m[4*i +: 4]);
        return v;
    endfunction

    function automatic logic [W-1:0] int2bcd(input int v);
        logic [W-1:0] m = '0;
        int t = v;
        for (int i = 0; i < D; i++) begin
            m[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return m;
    endfunction

    function automatic bit has_bad(input logic [W-1:0] m);
        for (int i = 0; i < D; i++) if (m[4*i +: 4] > 4'd9) return 1'b1;
        return 1'b0;
    endfunction

    function automatic exp_t model(input logic s, input logic as, input logic [W-1:0] am,
                                   input logic bs, input logic [W-1:0] bm);
        exp_t e;
        int p = 1;
        int ia, ib, r, mag;
        for (int i = 0; i < D; i++) p = p * 10;
        e.acc = 0;
        if (has_bad(am) || has_bad(bm)) begin
            e.s = 1'b0; e.m = '0; e.ov = 1'b0; e.inv = 1'b1; e.lat = 1;
        end else begin
            ia = as ? -bcd2int(am) : bcd2int(am);
            ib = bs ? -bcd2int(bm) : bcd2int(bm);
            r = s ? ia - ib : ia + ib;
            mag = (r < 0) ? -r : r;
            e.ov = (mag >= p);
            mag = mag % p;
            e.m = int2bcd(mag);
            e.s = (r < 0) && (mag != 0);
            e.inv = 1'b0;
            e.lat = ((as ^ bs ^ s) && (bcd2int(am) < bcd2int(bm))) ? 2 * D + 1 : D + 1;
        end
        return e;
    endfunction

    // in_done=1 raises start during the done pulse; it must only be taken on the following IDLE edge.
    task automatic do_op(input logic s, input logic as, input logic [W-1:0] am,
                         input logic bs, input logic [W-1:0] bm, input bit in_done);
        int n = 0;
        exp_t e;
        @(negedge clk);
        if (in_done) begin
            while (!done && n < 200) begin @(negedge clk); n++; end
        end else begin
            while ((busy || done) && n < 200) begin @(negedge clk); n++; end
        end
        if (n >= 200) check("wait_timeout", 1, 0);
        e = model(s, as, am, bs, bm);
        sub = s; a_sign = as; a_mag = am; b_sign = bs; b_mag = bm;
        start = 1'b1;
        if (in_done) begin
            @(posedge clk);
            #1 check("start_in_done_ignored", busy, 0);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        e.acc = cyc;
        q.push_back(e);
        check("busy_after_accept", busy, 1);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            h_s = 1'b0; h_m = '0; h_ov = 1'b0; h_inv = 1'b0;
        end else begin
            if (busy) begin
                check("hold_during_busy", {r_sign, r_mag, overflow, invalid}, {h_s, h_m, h_ov, h_inv});
                check("no_done_while_busy", done, 0);
            end
            if (done) begin
                ndone++;
                if (q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    e = q.pop_front();
                    check("r_sign", r_sign, e.s);
                    check("r_mag", r_mag, e.m);
                    check("overflow", overflow, e.ov);
                    check("invalid", invalid, e.inv);
                    check("latency", cyc - e.acc, e.lat);
                    check("busy_at_done", busy, 0);
                end
                h_s = r_sign; h_m = r_mag; h_ov = overflow; h_inv = invalid;
            end
        end
    end

    initial begin
        int n;
        int nd;
        logic [W-1:0] ra, rb;

        repeat (2) @(negedge clk);
        check("rst_outputs", {busy, done, r_sign, r_mag, overflow, invalid}, '0);
        rst_n = 1'b1;

        do_op(0, 0, 12'h123, 0, 12'h456, 0);
        do_op(0, 0, 12'h999, 0, 12'h001, 0);
        do_op(1, 0, 12'h250, 0, 12'h750, 0);
        do_op(0, 1, 12'h300, 0, 12'h300, 0);
        do_op(1, 1, 12'h045, 1, 12'h045, 0);
        do_op(0, 0, 12'h12A, 0, 12'h001, 0);
        do_op(0, 0, 12'h001, 0, 12'h002, 0);
        do_op(1, 0, 12'h000, 0, 12'h001, 1);
        do_op(0, 1, 12'h999, 1, 12'h999, 1);

        // A start pulse while busy carries operands that must never show up in any result.
        do_op(0, 0, 12'h111, 0, 12'h222, 0);
        @(negedge clk);
        sub = 1'b1; a_sign = 1'b1; a_mag = 12'h999; b_mag = 12'h998; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        do_op(0, 0, 12'h010, 1, 12'h020, 0);

        // Reset during the second ADD cycle: outputs clear and no done follows.
        n = 0;
        @(negedge clk);
        while ((busy || done) && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) check("wait_timeout", 1, 0);
        sub = 1'b0; a_sign = 1'b0; a_mag = 12'h123; b_sign = 1'b0; b_mag = 12'h456;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check("abort_outputs", {busy, done, r_sign, r_mag, overflow, invalid}, '0);
        nd = ndone;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("no_done_after_abort", ndone, nd);

        for (int k = 0; k < 80; k++) begin
            ra = '0; rb = '0;
            for (int i = 0; i < D; i++) begin
                ra[4*i +: 4] = ($urandom_range(0, 29) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
                rb[4*i +: 4] = ($urandom_range(0, 29) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
            end
            if ($urandom_range(0, 7) == 0) rb = ra;
            do_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ra,
                  1'($urandom_range(0, 1)), rb, ($urandom_range(0, 4) == 0));
        end

        n = 0;
        while (q.size() != 0 && n < 200) begin @(negedge clk); n++; end
        if (q.size() != 0) check("drain_timeout", q.size(), 0);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
